// File: rtl/cordic_quadrant_prep.sv
// Quadrant fold and angle scaling ahead of the CORDIC rotator.
// Three-stage pipeline: fold+pre-rotate, multiply, round.
module cordic_quadrant_prep #(
    parameter int                 BIT_WIDTH = 8,
    parameter logic signed [31:0] K_HALF_PI = 32'sd1686629713
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [BIT_WIDTH-1:0] x_in,
    input  logic signed [BIT_WIDTH-1:0] y_in,
    input  logic        [31:0]          phase_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [BIT_WIDTH-1:0] x_out,
    output logic signed [BIT_WIDTH-1:0] y_out,
    output logic signed [31:0]          angle_out
);

    localparam logic signed [BIT_WIDTH-1:0] VMAX =
        {1'b0, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [BIT_WIDTH-1:0] VMIN =
        {1'b1, {(BIT_WIDTH-1){1'b0}}};

    function automatic logic signed [BIT_WIDTH-1:0] sat_neg(
        input logic signed [BIT_WIDTH-1:0] v
    );
        return (v == VMIN) ? VMAX : -v;
    endfunction

    logic                        en;
    logic                        s1_valid;
    logic                        s2_valid;
    logic                        s3_valid;
    logic signed [BIT_WIDTH-1:0] s1_x;
    logic signed [BIT_WIDTH-1:0] s1_y;
    logic signed [31:0]          s1_r;
    logic signed [BIT_WIDTH-1:0] s2_x;
    logic signed [BIT_WIDTH-1:0] s2_y;
    logic signed [63:0]          s2_m;

    logic        [31:0]          p;
    logic        [1:0]           q;
    logic        [31:0]          r;
    logic signed [BIT_WIDTH-1:0] rot_x;
    logic signed [BIT_WIDTH-1:0] rot_y;
    logic signed [63:0]          r_ext;
    logic signed [63:0]          k_ext;
    logic signed [63:0]          m_c;
    logic signed [63:0]          rnd;
    logic                        unused_bits;

    assign en        = !s3_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = s3_valid;

    // Bias by 45 deg so the top two bits pick the nearest quadrant.
    assign p = phase_in + 32'h2000_0000;
    assign q = p[31:30];
    assign r = phase_in - {q, 30'd0};

    always_comb begin
        rot_x = x_in;
        rot_y = y_in;
        unique case (q)
            2'd0: begin
                rot_x = x_in;
                rot_y = y_in;
            end
            2'd1: begin
                rot_x = sat_neg(y_in);
                rot_y = x_in;
            end
            2'd2: begin
                rot_x = sat_neg(x_in);
                rot_y = sat_neg(y_in);
            end
            2'd3: begin
                rot_x = y_in;
                rot_y = sat_neg(x_in);
            end
        endcase
    end

    assign r_ext = {{32{s1_r[31]}}, s1_r};
    assign k_ext = {{32{K_HALF_PI[31]}}, K_HALF_PI};
    assign m_c   = r_ext * k_ext;
    assign rnd   = s2_m + 64'sd536870912;

    assign unused_bits = ^{p[29:0], rnd[63:62], rnd[29:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            s1_x      <= '0;
            s1_y      <= '0;
            s1_r      <= '0;
            s2_x      <= '0;
            s2_y      <= '0;
            s2_m      <= '0;
            x_out     <= '0;
            y_out     <= '0;
            angle_out <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_x      <= rot_x;
            s1_y      <= rot_y;
            s1_r      <= r;
            s2_valid  <= s1_valid;
            s2_x      <= s1_x;
            s2_y      <= s1_y;
            s2_m      <= m_c;
            s3_valid  <= s2_valid;
            x_out     <= s2_x;
            y_out     <= s2_y;
            angle_out <= rnd[61:30];
        end
    end

endmodule

// File: tb/tb_cordic_quadrant_prep.sv
// Randomized scoreboard bench for cordic_quadrant_prep.
// Reference model works on whole-number angles and quadrant tables.
module tb_cordic_quadrant_prep;

    localparam int     BW   = 8;
    localparam longint K    = 64'sd1686629713;
    localparam longint QTR  = 64'sd1073741824;
    localparam longint TURN = 64'sd4294967296;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [BW-1:0] x_in;
    logic signed [BW-1:0] y_in;
    logic        [31:0]   phase_in;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [BW-1:0] x_out;
    logic signed [BW-1:0] y_out;
    logic signed [31:0]   angle_out;

    cordic_quadrant_prep #(
        .BIT_WIDTH(BW),
        .K_HALF_PI(32'sd1686629713)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_in     (x_in),
        .y_in     (y_in),
        .phase_in (phase_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x_out    (x_out),
        .y_out    (y_out),
        .angle_out(angle_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    int          n_out;
    logic [47:0] expq[$];
    logic [47:0] mon_e;
    bit          rnd_done;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic logic [47:0] model(input int x, input int y,
                                          input logic [31:0] ph);
        longint phl;
        longint q;
        longint r;
        longint t;
        longint a;
        int     ex;
        int     ey;
        phl = ph;
        q = ((phl + QTR / 2) % TURN) / QTR;
        r = phl - q * QTR;
        if (r >= TURN / 2) r = r - TURN;
        t = r * K + QTR / 2;
        a = t / QTR;
        if (t < 0 && (t % QTR) != 0) a = a - 1;
        case (q)
            0: begin ex = x;         ey = y;         end
            1: begin ex = clamp(-y); ey = x;         end
            2: begin ex = clamp(-x); ey = clamp(-y); end
            default: begin ex = y;   ey = clamp(-x); end
        endcase
        return {8'(ex), 8'(ey), 32'(a)};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (expq.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    mon_e = expq.pop_front();
                    check("sb_beat", {x_out, y_out, angle_out}, mon_e);
                end
            end
            if (in_valid && in_ready)
                expq.push_back(model(x_in, y_in, phase_in));
        end
    end

    task automatic send(input int x, input int y, input logic [31:0] ph);
        int g;
        x_in     = 8'(x);
        y_in     = 8'(y);
        phase_in = ph;
        in_valid = 1'b1;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic directed(input string tag, input int x, input int y,
                            input logic [31:0] ph, input int ex,
                            input int ey, input int ea);
        int lat;
        send(x, y, ph);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            @(negedge clk);
        end
        check($sformatf("%s_lat", tag), lat, 3);
        check($sformatf("%s_x", tag), x_out, ex);
        check($sformatf("%s_y", tag), y_out, ey);
        check($sformatf("%s_ang", tag), angle_out, ea);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while (expq.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check(tag, expq.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          start;
        int          g;
        logic [63:0] sx;
        logic [63:0] sy;
        logic [63:0] sa;
        logic [31:0] ph;
        int          rx;
        int          ry;

        n_checks = 0;
        n_fail   = 0;
        n_out    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x_in      = '0;
        y_in      = '0;
        phase_in  = '0;

        #12;
        check("rst_valid", out_valid, 0);
        check("rst_x", x_out, 0);
        check("rst_y", y_out, 0);
        check("rst_ang", angle_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);

        directed("rot45", 64, 0, 32'h2000_0000, 0, 64, -843314856);
        directed("ident", 50, -20, 32'h0000_0000, 50, -20, 0);
        directed("wrapneg", 30, 40, 32'hF000_0000, 30, 40, -421657428);
        directed("pos", 30, 40, 32'h1000_0000, 30, 40, 421657428);
        directed("sat", -128, 5, 32'h8000_0000, 127, -5, 0);
        directed("q3", 10, -128, 32'hC000_0000, -128, -10, 0);
        directed("tie135", 3, -7, 32'h6000_0000, -3, 7, -843314856);
        directed("edge", 3, -7, 32'h5FFF_FFFF, 7, 3, 843314855);

        // Backpressure: stall after the first output, then release.
        start = n_out;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(i * 7 - 20, 100 - i * 9, $urandom);
            end
            begin
                g = 0;
                @(negedge clk);
                while (!(out_valid && out_ready) && g < 50) begin
                    @(negedge clk);
                    g++;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                check("bp_stall_valid", out_valid, 1);
                check("bp_in_ready", in_ready, 0);
                sx = x_out;
                sy = y_out;
                sa = angle_out;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready", in_ready, 0);
                    check("bp_hold", {x_out, y_out, angle_out},
                          {sx[7:0], sy[7:0], sa[31:0]});
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("bp_drain");
        check("bp_count", n_out - start, 5);
        @(posedge clk);
        #1;

        // Reset with beats in flight.
        send(11, 22, 32'h0100_0000);
        send(-33, 44, 32'h4100_0000);
        send(55, -66, 32'h8100_0000);
        check("rst_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_x", x_out, 0);
        check("rst_mid_y", y_out, 0);
        check("rst_mid_ang", angle_out, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("rst_no_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;
        directed("post_rst", 64, 0, 32'h2000_0000, 0, 64, -843314856);

        // Random stream with random backpressure.
        rnd_done = 1'b0;
        start = n_out;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end else begin
                        rx = ($urandom_range(0, 7) == 0) ? -128
                             : int'($urandom_range(0, 255)) - 128;
                        ry = ($urandom_range(0, 7) == 0) ? -128
                             : int'($urandom_range(0, 255)) - 128;
                        if ($urandom_range(0, 3) == 0) begin
                            ph = 32'($urandom_range(0, 7)) << 29;
                            ph = ph + 32'($urandom_range(0, 2)) - 32'd1;
                        end else begin
                            ph = $urandom;
                        end
                        send(rx, ry, ph);
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain("rnd_drain");
        check("rnd_some_out", (n_out - start) > 100, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_quadrant_prep.md
Name: cordic_quadrant_prep

Overview:
- Pipelined pre-stage that sits directly upstream of the `cordic` rotator and drives its `Xin`, `Yin` and `angle` inputs.
- Accepts a full-circle 32-bit binary phase word and reduces it to a quadrant plus a residual in [-π/4, π/4).
- Pre-rotates the input vector by the quadrant multiple of 90°.
- Converts the residual into the 2.30 signed-radian format the rotator consumes, keeping every angle inside the rotator's convergence range.

Parameters:
- BIT_WIDTH, 8, width of the signed vector components; must match the rotator's BIT_WIDTH.
- K_HALF_PI, 32'sd1686629713, π/2 in signed 2.30 (round(π/2·2^30)).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat this cycle.
- x_in  in  BIT_WIDTH  signed vector X.
- y_in  in  BIT_WIDTH  signed vector Y.
- phase_in  in  32  unsigned binary angle; 2^32 = one full turn.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts; tie to 1 when feeding the free-running rotator.
- x_out  out  BIT_WIDTH  signed pre-rotated X, driven to the rotator's Xin.
- y_out  out  BIT_WIDTH  signed pre-rotated Y, driven to the rotator's Yin.
- angle_out  out  32  signed residual angle, 2.30 radians, driven to the rotator's angle.

Behaviour:
- Reset: rst_n low asynchronously clears all stage valid bits and all data registers.
  - out_valid=0, x_out=0, y_out=0, angle_out=0.
  - in_ready is 1 as soon as reset is released.
  - Reset mid-operation discards every in-flight beat; no partial beat emerges afterwards.
- Pipeline: three register stages S1, S2, S3 with one shared advance enable.
  - en = !s3_valid || out_ready; in_ready = en (combinational).
  - On en, every stage shifts by one: S1 takes the input beat and its valid bit; a bubble propagates as valid=0.
  - When en=0, all stages hold their data and valid bits.
  - Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
  - Latency is 3 cycles from input transfer to out_valid when never stalled; throughput is 1 beat/cycle.
- S1, quadrant fold:
  - p = phase_in + 2^29, modulo 2^32 (wraps).
  - q = p[31:30].
  - r = phase_in − (q<<30) as a 32-bit wrap, interpreted signed; r lies in [−2^29, 2^29).
  - Tie rule: an exact odd multiple of 45° rounds to the higher quadrant, giving r = −2^29.
  - Vector pre-rotation:
    - q=0 → (x, y)
    - q=1 → (−y, x)
    - q=2 → (−x, −y)
    - q=3 → (y, −x)
  - Negation saturates: −(−2^(BIT_WIDTH−1)) = 2^(BIT_WIDTH−1)−1; no other clipping.
- S2: full signed product m = r · K_HALF_PI, 64 bits wide; the vector is carried alongside unchanged.
- S3: angle_out = (m + 2^29) >>> 30, i.e. round-half-up arithmetic shift, truncated to 32 bits.
  - |angle_out| ≤ 843314857, so the result never overflows.
- Outputs are registered. x_out, y_out and angle_out change only when S3 loads, and are held while out_valid && !out_ready.
- When in_valid=0 during an advance, the data registers may load don't-care values; only valid bits are architectural. The bench checks data only when out_valid=1.

Test Plan:
- Rotation case: x_in=64, y_in=0, phase_in=32'h2000_0000 (45°), out_ready=1 → 3 cycles later out_valid=1, x_out=0, y_out=64, angle_out=−843314856.
- Identity and wrap:
  - phase_in=0, (x,y)=(50,−20) → (50,−20), angle_out=0.
  - phase_in=32'hF000_0000 → q=0, vector unchanged, angle_out=−421657428.
  - phase_in=32'h1000_0000 → angle_out=+421657428.
- Saturation: phase_in=32'h8000_0000, (x,y)=(−128,5) → x_out=127, y_out=−5, angle_out=0.
- Quadrant 3: phase_in=32'hC000_0000, (x,y)=(10,−128) → x_out=−128, y_out=−10, angle_out=0.
- Backpressure:
  - Stream 5 beats back-to-back, then drop out_ready after the first output → in_ready=0 while S3 is full.
  - x_out, y_out and angle_out stay stable while stalled.
  - On release, all 5 beats emerge in order with no loss or duplication.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight → out_valid=0 and outputs=0 immediately, without waiting for a clock edge. No stale beat appears after release; the first new beat appears 3 cycles after its acceptance.
